// File: rtl/omsp_spm_table.sv
// Protection table for NUM_SM software modules: a sequential scan engine that
// allocates and frees entries, plus combinational runtime access checks.
module omsp_spm_table #(
    parameter int NUM_SM = 4,
    parameter int ADDR_W = 16,
    parameter int ID_W   = 16
) (
    input  logic                          mclk,
    input  logic                          puc_rst,
    input  logic                          cfg_req,
    input  logic                          cfg_op,
    input  logic [ADDR_W-1:0]             cfg_pub_start,
    input  logic [ADDR_W-1:0]             cfg_pub_end,
    input  logic [ADDR_W-1:0]             cfg_sec_start,
    input  logic [ADDR_W-1:0]             cfg_sec_end,
    input  logic [ADDR_W-1:0]             cfg_pc,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic [2:0]                    cfg_status,
    output logic [ID_W-1:0]               cfg_id,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [ADDR_W-1:0]             prev_pc,
    input  logic [ADDR_W-1:0]             mab,
    input  logic [ADDR_W-1:0]             dma_addr,
    input  logic                          mb_en,
    input  logic                          dma_en,
    input  logic [1:0]                    mb_wr,
    output logic                          executing,
    output logic [ID_W-1:0]               exec_id,
    output logic                          violation,
    output logic                          dma_violation,
    output logic [$clog2(NUM_SM+1)-1:0]   active_count
);

    localparam int IDX_W = $clog2(NUM_SM);
    localparam int CNT_W = $clog2(NUM_SM+1);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_RANGE   = 3'd1;
    localparam logic [2:0] ST_OVERLAP = 3'd2;
    localparam logic [2:0] ST_FULL    = 3'd3;
    localparam logic [2:0] ST_NOTFND  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_DONE_ERR} state_t;

    function automatic logic f_in(input logic [ADDR_W-1:0] a, s, e);
        return (a >= s) && (a < e);
    endfunction

    // Half-open overlap; a zero-length region never overlaps anything.
    function automatic logic f_ovl(input logic [ADDR_W-1:0] as, ae, bs, be);
        return (as < be) && (bs < ae) && (as < ae) && (bs < be);
    endfunction

    function automatic logic [ID_W-1:0] f_next_id(input logic [ID_W-1:0] id);
        return (id == {ID_W{1'b1}}) ? ID_W'(1) : id + ID_W'(1);
    endfunction

    // Table
    logic [NUM_SM-1:0] r_en;
    logic [ID_W-1:0]   r_tid [NUM_SM];
    logic [ADDR_W-1:0] r_ps  [NUM_SM];
    logic [ADDR_W-1:0] r_pe  [NUM_SM];
    logic [ADDR_W-1:0] r_ss  [NUM_SM];
    logic [ADDR_W-1:0] r_se  [NUM_SM];

    // Engine control
    state_t            r_state, w_nstate;
    logic [IDX_W-1:0]  r_idx;
    logic              r_ovl, r_free_vld, r_tgt_vld;
    logic [IDX_W-1:0]  r_free_idx, r_tgt_idx;
    logic [ID_W-1:0]   r_tgt_id;
    logic [ID_W-1:0]   r_next_id;
    logic [2:0]        r_cfg_status;
    logic [ID_W-1:0]   r_cfg_id;

    // Captured request
    logic              r_op;
    logic [ADDR_W-1:0] r_c_ps, r_c_pe, r_c_ss, r_c_se, r_c_pc;

    logic              w_accept, w_invalid, w_ent_ovl, w_ent_tgt;
    logic              w_c_write, w_c_clear;
    logic [2:0]        w_c_status;
    logic [ID_W-1:0]   w_c_id;

    assign w_invalid = !(cfg_pub_start < cfg_pub_end) || (cfg_sec_start > cfg_sec_end) ||
                       f_ovl(cfg_pub_start, cfg_pub_end, cfg_sec_start, cfg_sec_end);

    assign w_ent_ovl = r_en[r_idx] &&
                       (f_ovl(r_c_ps, r_c_pe, r_ps[r_idx], r_pe[r_idx]) ||
                        f_ovl(r_c_ps, r_c_pe, r_ss[r_idx], r_se[r_idx]) ||
                        f_ovl(r_c_ss, r_c_se, r_ps[r_idx], r_pe[r_idx]) ||
                        f_ovl(r_c_ss, r_c_se, r_ss[r_idx], r_se[r_idx]));
    assign w_ent_tgt = r_en[r_idx] && f_in(r_c_pc, r_ps[r_idx], r_pe[r_idx]);

    always_comb begin
        w_nstate = r_state;
        w_accept = 1'b0;
        cfg_busy = 1'b0;
        cfg_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_req) begin
                    w_accept = 1'b1;
                    w_nstate = (!cfg_op && w_invalid) ? S_DONE_ERR : S_SCAN;
                end
            end
            S_SCAN: begin
                cfg_busy = 1'b1;
                if (r_idx == IDX_W'(NUM_SM-1)) w_nstate = S_COMMIT;
            end
            S_COMMIT: begin
                cfg_busy = 1'b1;
                cfg_done = 1'b1;
                w_nstate = S_IDLE;
            end
            default: begin
                cfg_busy = 1'b1;
                cfg_done = 1'b1;
                w_nstate = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_c_status = ST_OK;
        w_c_id     = '0;
        if (r_state == S_DONE_ERR) begin
            w_c_status = ST_RANGE;
        end else if (!r_op) begin
            if (r_ovl)            w_c_status = ST_OVERLAP;
            else if (!r_free_vld) w_c_status = ST_FULL;
            else                  w_c_id     = r_next_id;
        end else begin
            if (!r_tgt_vld) w_c_status = ST_NOTFND;
            else            w_c_id     = r_tgt_id;
        end
    end

    assign w_c_write  = (r_state == S_COMMIT) && !r_op && !r_ovl && r_free_vld;
    assign w_c_clear  = (r_state == S_COMMIT) && r_op && r_tgt_vld;
    // Result is visible in the done cycle itself, then held in registers.
    assign cfg_status = cfg_done ? w_c_status : r_cfg_status;
    assign cfg_id     = cfg_done ? w_c_id     : r_cfg_id;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_ovl        <= 1'b0;
            r_free_vld   <= 1'b0;
            r_free_idx   <= '0;
            r_tgt_vld    <= 1'b0;
            r_tgt_idx    <= '0;
            r_tgt_id     <= '0;
            r_next_id    <= ID_W'(1);
            r_cfg_status <= ST_OK;
            r_cfg_id     <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_accept) begin
                r_idx      <= '0;
                r_ovl      <= 1'b0;
                r_free_vld <= 1'b0;
                r_tgt_vld  <= 1'b0;
            end
            if (r_state == S_SCAN) begin
                r_idx <= r_idx + IDX_W'(1);
                if (w_ent_ovl) r_ovl <= 1'b1;
                if (!r_en[r_idx] && !r_free_vld) begin
                    r_free_vld <= 1'b1;
                    r_free_idx <= r_idx;
                end
                if (w_ent_tgt && !r_tgt_vld) begin
                    r_tgt_vld <= 1'b1;
                    r_tgt_idx <= r_idx;
                    r_tgt_id  <= r_tid[r_idx];
                end
            end
            if (cfg_done) begin
                r_cfg_status <= w_c_status;
                r_cfg_id     <= w_c_id;
            end
            if (w_c_write) r_next_id <= f_next_id(r_next_id);
        end
    end

    always_ff @(posedge mclk) begin
        if (w_accept) begin
            r_op   <= cfg_op;
            r_c_ps <= cfg_pub_start;
            r_c_pe <= cfg_pub_end;
            r_c_ss <= cfg_sec_start;
            r_c_se <= cfg_sec_end;
            r_c_pc <= cfg_pc;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_en <= '0;
            for (int i = 0; i < NUM_SM; i++) begin
                r_tid[i] <= '0;
                r_ps[i]  <= '0;
                r_pe[i]  <= '0;
                r_ss[i]  <= '0;
                r_se[i]  <= '0;
            end
        end else if (w_c_write) begin
            r_en[r_free_idx]  <= 1'b1;
            r_tid[r_free_idx] <= r_next_id;
            r_ps[r_free_idx]  <= r_c_ps;
            r_pe[r_free_idx]  <= r_c_pe;
            r_ss[r_free_idx]  <= r_c_ss;
            r_se[r_free_idx]  <= r_c_se;
        end else if (w_c_clear) begin
            r_en[r_tgt_idx]  <= 1'b0;
            r_tid[r_tgt_idx] <= '0;
            r_ps[r_tgt_idx]  <= '0;
            r_pe[r_tgt_idx]  <= '0;
            r_ss[r_tgt_idx]  <= '0;
            r_se[r_tgt_idx]  <= '0;
        end
    end

    // Runtime enforcement, per entry then reduced
    logic [NUM_SM-1:0] w_exec, w_viol, w_dma;

    for (genvar g = 0; g < NUM_SM; g++) begin : g_ent
        logic w_acc_pub, w_acc_sec, w_pc_in;
        assign w_pc_in   = f_in(pc, r_ps[g], r_pe[g]);
        assign w_acc_pub = mb_en && f_in(mab, r_ps[g], r_pe[g]);
        assign w_acc_sec = mb_en && f_in(mab, r_ss[g], r_se[g]);
        assign w_exec[g] = r_en[g] && w_pc_in;
        assign w_viol[g] = r_en[g] &&
                           ((w_acc_pub && !(w_pc_in && (mb_wr == 2'b00))) ||
                            (w_acc_sec && !w_pc_in) ||
                            (w_pc_in && !f_in(prev_pc, r_ps[g], r_pe[g]) && (pc != r_ps[g])));
        assign w_dma[g]  = r_en[g] && dma_en &&
                           (f_in(dma_addr, r_ps[g], r_pe[g]) || f_in(dma_addr, r_ss[g], r_se[g]));
    end

    assign executing     = |w_exec;
    assign violation     = |w_viol;
    assign dma_violation = |w_dma;

    always_comb begin
        exec_id      = '0;
        active_count = '0;
        for (int i = NUM_SM-1; i >= 0; i--) begin
            if (w_exec[i]) exec_id = r_tid[i];
            active_count = active_count + CNT_W'(r_en[i]);
        end
    end

endmodule

// File: tb/tb_omsp_spm_table.sv
// Scoreboarded bench for omsp_spm_table: directed scenarios then random
// enable/disable traffic and runtime probes against a behavioural table model.
module tb_omsp_spm_table;

    localparam int NUM_SM = 4;
    localparam int ADDR_W = 16;
    localparam int ID_W   = 16;
    localparam int CNT_W  = $clog2(NUM_SM+1);

    logic              mclk = 1'b0;
    logic              puc_rst;
    logic              cfg_req, cfg_op;
    logic [ADDR_W-1:0] cfg_pub_start, cfg_pub_end, cfg_sec_start, cfg_sec_end, cfg_pc;
    logic              cfg_busy, cfg_done;
    logic [2:0]        cfg_status;
    logic [ID_W-1:0]   cfg_id;
    logic [ADDR_W-1:0] pc, prev_pc, mab, dma_addr;
    logic              mb_en, dma_en;
    logic [1:0]        mb_wr;
    logic              executing, violation, dma_violation;
    logic [ID_W-1:0]   exec_id;
    logic [CNT_W-1:0]  active_count;

    omsp_spm_table #(.NUM_SM(NUM_SM), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .cfg_req(cfg_req), .cfg_op(cfg_op),
        .cfg_pub_start(cfg_pub_start), .cfg_pub_end(cfg_pub_end),
        .cfg_sec_start(cfg_sec_start), .cfg_sec_end(cfg_sec_end), .cfg_pc(cfg_pc),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_status(cfg_status), .cfg_id(cfg_id),
        .pc(pc), .prev_pc(prev_pc), .mab(mab), .dma_addr(dma_addr),
        .mb_en(mb_en), .dma_en(dma_en), .mb_wr(mb_wr),
        .executing(executing), .exec_id(exec_id), .violation(violation),
        .dma_violation(dma_violation), .active_count(active_count)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: a list of slots plus the id allocator
    bit        m_en [NUM_SM];
    logic [15:0] m_id [NUM_SM];
    logic [15:0] m_ps [NUM_SM];
    logic [15:0] m_pe [NUM_SM];
    logic [15:0] m_ss [NUM_SM];
    logic [15:0] m_se [NUM_SM];
    logic [15:0] m_next;

    typedef struct { logic [2:0] st; logic [15:0] id; int cyc; } exp_t;
    exp_t exp_q[$];

    function automatic bit inr(input logic [15:0] a, s, e);
        return (a >= s) && (a < e);
    endfunction

    // Two ranges share an address iff the larger start lies below the smaller end.
    function automatic bit share(input logic [15:0] as, ae, bs, be);
        logic [15:0] lo, hi;
        lo = (as > bs) ? as : bs;
        hi = (ae < be) ? ae : be;
        return lo < hi;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_SM; i++) begin
            m_en[i] = 0; m_id[i] = 0; m_ps[i] = 0; m_pe[i] = 0; m_ss[i] = 0; m_se[i] = 0;
        end
        m_next = 16'd1;
    endtask

    task automatic model_cfg(input bit op, input logic [15:0] ps, pe, ss, se, cpc,
                             output logic [2:0] st, output logic [15:0] id);
        int slot;
        st = 3'd0; id = 16'd0; slot = -1;
        if (!op) begin
            if (!(ps < pe) || ss > se || share(ps, pe, ss, se)) begin
                st = 3'd1;
                return;
            end
            for (int i = 0; i < NUM_SM; i++)
                if (m_en[i] && (share(ps, pe, m_ps[i], m_pe[i]) || share(ps, pe, m_ss[i], m_se[i]) ||
                                share(ss, se, m_ps[i], m_pe[i]) || share(ss, se, m_ss[i], m_se[i])))
                    st = 3'd2;
            if (st != 0) return;
            for (int i = NUM_SM-1; i >= 0; i--) if (!m_en[i]) slot = i;
            if (slot < 0) begin st = 3'd3; return; end
            m_en[slot] = 1; m_id[slot] = m_next; m_ps[slot] = ps; m_pe[slot] = pe;
            m_ss[slot] = ss; m_se[slot] = se;
            id = m_next;
            m_next = (m_next == 16'hFFFF) ? 16'd1 : m_next + 16'd1;
        end else begin
            for (int i = NUM_SM-1; i >= 0; i--) if (m_en[i] && inr(cpc, m_ps[i], m_pe[i])) slot = i;
            if (slot < 0) begin st = 3'd4; return; end
            id = m_id[slot];
            m_en[slot] = 0; m_id[slot] = 0; m_ps[slot] = 0; m_pe[slot] = 0; m_ss[slot] = 0; m_se[slot] = 0;
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation
    always @(negedge mclk) begin
        if (cfg_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: got status %0d id %0h with nothing outstanding", cfg_status, cfg_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_status", 32'(cfg_status), 32'(e.st));
                chk("done_id", 32'(cfg_id), 32'(e.id));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 64 && cfg_busy; k++) @(negedge mclk);
        if (cfg_busy) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: busy still 1 after 64 cycles, required 0", nm);
        end
    endtask

    task automatic do_cfg(input bit op, input logic [15:0] ps, pe, ss, se, cpc, input bit poke);
        logic [2:0] st;
        logic [15:0] id;
        @(negedge mclk);
        cfg_req = 1; cfg_op = op;
        cfg_pub_start = ps; cfg_pub_end = pe; cfg_sec_start = ss; cfg_sec_end = se; cfg_pc = cpc;
        model_cfg(op, ps, pe, ss, se, cpc, st, id);
        exp_q.push_back('{st, id, cyc + ((st == 3'd1) ? 1 : NUM_SM + 1)});
        @(negedge mclk);
        cfg_req = 0;
        chk("busy_cycle1", 32'(cfg_busy), 32'd1);
        if (poke) begin
            @(negedge mclk);
            cfg_req = 1; cfg_op = 1'b0;
            cfg_pub_start = 16'hA000; cfg_pub_end = 16'hA100; cfg_sec_start = 16'h0A00; cfg_sec_end = 16'h0A10;
            @(negedge mclk);
            cfg_req = 0;
        end
        wait_idle("cfg");
        chk("status_held", 32'(cfg_status), 32'(st));
        chk("id_held", 32'(cfg_id), 32'(id));
    endtask

    task automatic probe(input logic [15:0] p, pp, ma, input bit me, input logic [1:0] wr,
                         input bit de, input logic [15:0] da);
        bit e_exec, e_viol, e_dma, ex;
        logic [15:0] e_id;
        int e_cnt;
        @(negedge mclk);
        pc = p; prev_pc = pp; mab = ma; mb_en = me; mb_wr = wr; dma_en = de; dma_addr = da;
        #1;
        e_exec = 0; e_viol = 0; e_dma = 0; e_id = 0; e_cnt = 0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (!m_en[i]) continue;
            e_cnt++;
            ex = inr(p, m_ps[i], m_pe[i]);
            if (ex) begin e_exec = 1; e_id = m_id[i]; end
            if (me && inr(ma, m_ps[i], m_pe[i]) && !(ex && wr == 2'b00)) e_viol = 1;
            if (me && inr(ma, m_ss[i], m_se[i]) && !ex) e_viol = 1;
            if (ex && !inr(pp, m_ps[i], m_pe[i]) && p != m_ps[i]) e_viol = 1;
            if (de && (inr(da, m_ps[i], m_pe[i]) || inr(da, m_ss[i], m_se[i]))) e_dma = 1;
        end
        chk("executing", 32'(executing), 32'(e_exec));
        chk("exec_id", 32'(exec_id), 32'(e_id));
        chk("violation", 32'(violation), 32'(e_viol));
        chk("dma_violation", 32'(dma_violation), 32'(e_dma));
        chk("active_count", 32'(active_count), 32'(e_cnt));
    endtask

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return m_ps[$urandom_range(0, NUM_SM-1)];
        if ($urandom_range(0, 1) == 0) return 16'(16'h7FE0 + $urandom_range(0, 16'h0840));
        return 16'(16'h02F0 + $urandom_range(0, 16'h0480));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ps, pe, ss, se;
        puc_rst = 1; cfg_req = 0; cfg_op = 0;
        cfg_pub_start = 0; cfg_pub_end = 0; cfg_sec_start = 0; cfg_sec_end = 0; cfg_pc = 0;
        pc = 16'h8000; prev_pc = 16'h9000; mab = 16'h8000; mb_en = 1; mb_wr = 2'b11;
        dma_en = 1; dma_addr = 16'h8000;
        model_reset();
        repeat (3) @(negedge mclk);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_status", 32'(cfg_status), 32'd0);
        chk("rst_id", 32'(cfg_id), 32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        chk("rst_viol", 32'(violation), 32'd0);
        chk("rst_dma", 32'(dma_violation), 32'd0);
        chk("rst_exec", 32'(executing), 32'd0);
        puc_rst = 0;
        mb_en = 0; dma_en = 0;

        // Directed scenarios
        do_cfg(0, 16'h8000, 16'h8100, 16'h0300, 16'h0320, 16'h0, 0);
        probe(16'h9000, 16'h8FFE, 16'h0300, 1, 2'b00, 0, 16'h0);
        probe(16'h8010, 16'h8000, 16'h0300, 1, 2'b00, 0, 16'h0);
        do_cfg(0, 16'h80F0, 16'h8200, 16'h0400, 16'h0410, 16'h0, 0);
        do_cfg(0, 16'h8400, 16'h8500, 16'h8050, 16'h8060, 16'h0, 0);
        do_cfg(0, 16'h8600, 16'h8600, 16'h0000, 16'h0000, 16'h0, 0);
        do_cfg(0, 16'h8200, 16'h8300, 16'h0500, 16'h0510, 16'h0, 0);
        do_cfg(0, 16'h8300, 16'h8400, 16'h0600, 16'h0610, 16'h0, 0);
        do_cfg(0, 16'h8400, 16'h8500, 16'h0700, 16'h0710, 16'h0, 0);
        do_cfg(0, 16'h8600, 16'h8700, 16'h0800, 16'h0810, 16'h0, 0);
        do_cfg(1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8004, 0);
        probe(16'h9000, 16'h9000, 16'h0, 0, 2'b00, 0, 16'h0);
        do_cfg(0, 16'h8000, 16'h8100, 16'h0300, 16'h0320, 16'h0, 0);
        probe(16'h8002, 16'h9000, 16'h0, 0, 2'b00, 0, 16'h0);
        probe(16'h8000, 16'h9000, 16'h0, 0, 2'b00, 0, 16'h0);
        probe(16'h9000, 16'h9000, 16'h0, 0, 2'b00, 1, 16'h0310);
        probe(16'h9000, 16'h9000, 16'h0, 0, 2'b00, 1, 16'h0320);
        probe(16'h8050, 16'h8040, 16'h8060, 1, 2'b01, 0, 16'h0);
        do_cfg(1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8250, 1);

        // Reset in the middle of a scan: nothing committed, no completion
        @(negedge mclk);
        cfg_req = 1; cfg_op = 0;
        cfg_pub_start = 16'h8800; cfg_pub_end = 16'h8900; cfg_sec_start = 16'h0900; cfg_sec_end = 16'h0910;
        @(negedge mclk);
        cfg_req = 0;
        @(negedge mclk);
        puc_rst = 1;
        @(negedge mclk);
        puc_rst = 0;
        model_reset();
        chk("midrst_busy", 32'(cfg_busy), 32'd0);
        chk("midrst_count", 32'(active_count), 32'd0);
        chk("midrst_status", 32'(cfg_status), 32'd0);
        chk("midrst_id", 32'(cfg_id), 32'd0);
        repeat (NUM_SM + 3) @(negedge mclk);
        probe(16'h8800, 16'h9000, 16'h0900, 1, 2'b00, 1, 16'h8000);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            bit op;
            op = ($urandom_range(0, 2) == 0);
            ps = 16'(16'h8000 + $urandom_range(0, 15) * 16'h40);
            pe = 16'(ps + $urandom_range(0, 4) * 16'h20);
            if ($urandom_range(0, 7) == 0) ss = 16'(16'h8000 + $urandom_range(0, 31) * 16'h20);
            else                           ss = 16'(16'h0300 + $urandom_range(0, 15) * 16'h20);
            se = 16'(ss + $urandom_range(0, 3) * 16'h10);
            do_cfg(op, ps, pe, ss, se, 16'(16'h8000 + $urandom_range(0, 16'h400)), 0);
            for (int k = 0; k < 4; k++)
                probe(rnd_addr(), rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_addr());
        end

        repeat (2) @(negedge mclk);
        chk("pending_done", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
